// File: rtl/uart_awg_pkg.sv
// Shared constants and types for the AWG UART configuration receiver.
//   HDR / BCAST_GA / IDX_COMMIT : frame byte values
//   field_e                     : register field selector within a channel/segment
//   pstate_e                    : frame parser states
//   reg_idx()                   : flat register index for (field, seg, ch)
package uart_awg_pkg;

  localparam logic [7:0] HDR        = 8'hAA;
  localparam logic [7:0] BCAST_GA   = 8'h1F;
  localparam logic [7:0] IDX_COMMIT = 8'hFF;

  typedef enum logic [1:0] {DELAY, LEN, ADDR} field_e;

  typedef enum logic [2:0] {P_IDLE, P_GA, P_IDX, P_DATA, P_CSUM} pstate_e;

  // Fields are the outermost dimension, channels the innermost.
  function automatic int reg_idx(field_e f, int seg, int ch, int nch, int nseg);
    return int'(f) * nch * nseg + seg * nch + ch;
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// UART byte receiver: 2-FF synchroniser, start/data/stop sampling, framing check.
//   clk, rst   : system clock, async active-high reset
//   rxb        : raw serial line, idle high
//   rx_byte    : last received byte (valid with byte_vld)
//   byte_vld   : 1-cycle strobe, byte received with a good stop bit
//   frame_err  : 1-cycle strobe, stop bit read low (byte dropped)
module uart_rx_byte #(
  parameter int DIV = 87
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxb,
  output logic [7:0] rx_byte,
  output logic       byte_vld,
  output logic       frame_err
);

  localparam int CW   = $clog2(DIV + 1);
  localparam int HALF = DIV / 2;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_e;

  rstate_e       st;
  logic [1:0]    sync;
  logic          rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync      <= 2'b11;
      rx_prev   <= 1'b1;
      st        <= R_IDLE;
      cnt       <= '0;
      bitn      <= '0;
      sh        <= '0;
      rx_byte   <= '0;
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync      <= {sync[0], rxb};
      rx_prev   <= sync[1];
      byte_vld  <= 1'b0;
      frame_err <= 1'b0;
      case (st)
        R_IDLE: begin
          cnt <= '0;
          if (rx_prev && !sync[1]) st <= R_START;
        end
        // Mid-bit check of the start bit rejects glitches on the line.
        R_START: begin
          if (cnt == CW'(HALF)) begin
            cnt  <= '0;
            bitn <= '0;
            st   <= sync[1] ? R_IDLE : R_DATA;
          end else cnt <= cnt + 1'b1;
        end
        R_DATA: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt  <= '0;
            sh   <= {sync[1], sh[7:1]};
            bitn <= bitn + 1'b1;
            if (bitn == 3'd7) st <= R_STOP;
          end else cnt <= cnt + 1'b1;
        end
        R_STOP: begin
          if (cnt == CW'(DIV - 1)) begin
            cnt <= '0;
            st  <= R_IDLE;
            if (sync[1]) begin
              rx_byte  <= sh;
              byte_vld <= 1'b1;
            end else frame_err <= 1'b1;
          end else cnt <= cnt + 1'b1;
        end
        default: st <= R_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_awg_cfg_rx.sv
// AWG configuration receiver. Parses addressed, checksummed UART frames into a
// shadow register bank and copies it to the active bank on a commit frame.
//   I_clk_10M    : system clock
//   I_rst        : async active-high reset
//   I_rxb        : UART line, idle high
//   I_GA         : board geographic address
//   O_cfg        : active bank, register k at [k*FIELD_W +: FIELD_W]
//   O_cfg_update : 1-cycle pulse on commit
//   O_frame_ok   : 1-cycle pulse per accepted write or commit frame
//   O_err_cnt    : saturating framing/checksum/timeout error count
module uart_awg_cfg_rx
  import uart_awg_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 10_000_000,
  parameter int BAUD        = 115_200,
  parameter int NUM_CH      = 4,
  parameter int NUM_SEG     = 3,
  parameter int FIELD_W     = 24,
  parameter int TIMEOUT_CYC = 20 * ((CLK_FREQ_HZ + BAUD / 2) / BAUD)
) (
  input  logic                                   I_clk_10M,
  input  logic                                   I_rst,
  input  logic                                   I_rxb,
  input  logic [4:0]                             I_GA,
  output logic [3*NUM_CH*NUM_SEG*FIELD_W-1:0]    O_cfg,
  output logic                                   O_cfg_update,
  output logic                                   O_frame_ok,
  output logic [7:0]                             O_err_cnt
);

  localparam int DIV  = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int NB   = (FIELD_W + 7) / 8;
  localparam int DW   = NB * 8;
  localparam int NREG = 3 * NUM_CH * NUM_SEG;
  localparam int TW   = $clog2(TIMEOUT_CYC + 1);
  localparam int DCW  = $clog2(NB + 1);

  // Register indices travel in one byte and 0xFF is reserved for commit.
  generate
    if (NREG > 255) begin : g_nreg_chk
      $error("uart_awg_cfg_rx: NREG must be <= 255");
    end
  endgenerate

  logic [7:0] rx_byte;
  logic       byte_vld, frame_err;

  uart_rx_byte #(.DIV(DIV)) u_rx (
    .clk       (I_clk_10M),
    .rst       (I_rst),
    .rxb       (I_rxb),
    .rx_byte   (rx_byte),
    .byte_vld  (byte_vld),
    .frame_err (frame_err)
  );

  pstate_e                        pst;
  logic                           match;
  logic [7:0]                     idx;
  logic [7:0]                     csum;
  logic [DW-1:0]                  dsh;
  logic [DCW-1:0]                 dcnt;
  logic [TW-1:0]                  tmo;
  logic [NREG-1:0][FIELD_W-1:0]   shadow;
  logic [NREG-1:0][FIELD_W-1:0]   cfg;

  logic tmo_hit, csum_bad, err_inc;

  assign tmo_hit  = (pst != P_IDLE) && !byte_vld && (tmo == TW'(TIMEOUT_CYC - 1));
  // Bad checksums on frames for other boards are not this board's problem.
  assign csum_bad = byte_vld && (pst == P_CSUM) && match && (rx_byte != csum);
  // Every framing error counts, even between frames; sources merge to one step.
  assign err_inc  = tmo_hit | csum_bad | frame_err;

  assign O_cfg = cfg;

  always_ff @(posedge I_clk_10M or posedge I_rst) begin
    if (I_rst) begin
      pst          <= P_IDLE;
      match        <= 1'b0;
      idx          <= '0;
      csum         <= '0;
      dsh          <= '0;
      dcnt         <= '0;
      tmo          <= '0;
      shadow       <= '0;
      cfg          <= '0;
      O_cfg_update <= 1'b0;
      O_frame_ok   <= 1'b0;
      O_err_cnt    <= '0;
    end else begin
      O_cfg_update <= 1'b0;
      O_frame_ok   <= 1'b0;
      if (err_inc && O_err_cnt != 8'hFF) O_err_cnt <= O_err_cnt + 8'd1;
      if (pst == P_IDLE || byte_vld) tmo <= '0;
      else                           tmo <= tmo + 1'b1;

      if (frame_err || tmo_hit) pst <= P_IDLE;
      else if (byte_vld) begin
        case (pst)
          P_IDLE: if (rx_byte == HDR) pst <= P_GA;
          P_GA: begin
            match <= (rx_byte == {3'b000, I_GA}) || (rx_byte == BCAST_GA);
            csum  <= rx_byte;
            pst   <= P_IDX;
          end
          P_IDX: begin
            idx  <= rx_byte;
            csum <= csum ^ rx_byte;
            dcnt <= '0;
            pst  <= P_DATA;
          end
          P_DATA: begin
            dsh  <= (dsh << 8) | DW'(rx_byte);
            csum <= csum ^ rx_byte;
            dcnt <= dcnt + 1'b1;
            if (dcnt == DCW'(NB - 1)) pst <= P_CSUM;
          end
          P_CSUM: begin
            pst <= P_IDLE;
            if (match && rx_byte == csum) begin
              if (idx == IDX_COMMIT) begin
                cfg          <= shadow;
                O_cfg_update <= 1'b1;
                O_frame_ok   <= 1'b1;
              end else if (idx < 8'(NREG)) begin
                for (int k = 0; k < NREG; k++)
                  if (idx == 8'(k)) shadow[k] <= dsh[FIELD_W-1:0];
                O_frame_ok <= 1'b1;
              end
            end
          end
          default: pst <= P_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_awg_cfg_rx.sv
// Directed bench for uart_awg_cfg_rx. Baud is raised so one bit is 16 clocks,
// which keeps the 300-byte saturation run short; timeout is then 320 clocks.
module tb_uart_awg_cfg_rx;

  localparam int DIV  = 16;
  localparam int NREG = 36;
  localparam int FW   = 24;
  localparam int CW   = NREG * FW;

  logic          clk = 1'b0;
  logic          rst;
  logic          rxb;
  logic [4:0]    ga;
  logic [CW-1:0] cfg;
  logic          upd, fok;
  logic [7:0]    errc;

  logic [CW-1:0] exp_cfg;
  int errors = 0, checks = 0;
  int ok_cnt = 0, upd_cnt = 0;
  int o0, u0;

  uart_awg_cfg_rx #(
    .CLK_FREQ_HZ (10_000_000),
    .BAUD        (625_000),
    .NUM_CH      (4),
    .NUM_SEG     (3),
    .FIELD_W     (FW)
  ) dut (
    .I_clk_10M    (clk),
    .I_rst        (rst),
    .I_rxb        (rxb),
    .I_GA         (ga),
    .O_cfg        (cfg),
    .O_cfg_update (upd),
    .O_frame_ok   (fok),
    .O_err_cnt    (errc)
  );

  always #50 clk = ~clk;

  always @(negedge clk) begin
    if (fok) ok_cnt++;
    if (upd) upd_cnt++;
  end

  task automatic bit_time();
    repeat (DIV) @(posedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxb = 1'b0; bit_time();
    for (int i = 0; i < 8; i++) begin rxb = b[i]; bit_time(); end
    rxb = stop_bit; bit_time();
    rxb = 1'b1;     bit_time();
  endtask

  task automatic send_frame(input logic [7:0] g, input logic [7:0] ix,
                            input logic [23:0] d, input logic [7:0] cs);
    send_byte(8'hAA, 1'b1);
    send_byte(g, 1'b1);
    send_byte(ix, 1'b1);
    send_byte(d[23:16], 1'b1);
    send_byte(d[15:8], 1'b1);
    send_byte(d[7:0], 1'b1);
    send_byte(cs, 1'b1);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic check_cfg(input string tag);
    int bad;
    bad = 0;
    for (int k = NREG - 1; k >= 0; k--)
      if (cfg[k*FW +: FW] !== exp_cfg[k*FW +: FW]) bad = k;
    checks++;
    assert (cfg === exp_cfg) else begin
      errors++;
      $error("FAIL %s: reg %0d got %h expected %h", tag, bad,
             cfg[bad*FW +: FW], exp_cfg[bad*FW +: FW]);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (3) @(negedge clk); rst = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  initial begin
    rst = 1'b1; rxb = 1'b1; ga = 5'd3; exp_cfg = '0;
    do_reset();
    check_cfg("reset_cfg");
    check("reset_err", 32'(errc), 32'h0);
    check("reset_upd", 32'(upd), 32'h0);
    check("reset_ok", 32'(fok), 32'h0);

    // 1: write reg 5, then commit
    o0 = ok_cnt;
    send_frame(8'h03, 8'h05, 24'h123456, 8'h76);
    check("t1_write_ok", 32'(ok_cnt - o0), 32'd1);
    check_cfg("t1_cfg_before_commit");
    o0 = ok_cnt; u0 = upd_cnt;
    send_frame(8'h03, 8'hFF, 24'h000000, 8'hFC);
    exp_cfg[5*FW +: FW] = 24'h123456;
    check_cfg("t1_cfg_commit");
    check("t1_commit_ok", 32'(ok_cnt - o0), 32'd1);
    check("t1_commit_upd", 32'(upd_cnt - u0), 32'd1);
    check("t1_err", 32'(errc), 32'h0);

    // 2: bad checksum from a clean bank
    do_reset();
    exp_cfg = '0;
    o0 = ok_cnt;
    send_frame(8'h03, 8'h05, 24'h123456, 8'h77);
    check("t2_err", 32'(errc), 32'h1);
    check("t2_no_ok", 32'(ok_cnt - o0), 32'd0);
    o0 = ok_cnt; u0 = upd_cnt;
    send_frame(8'h03, 8'hFF, 24'h000000, 8'hFC);
    check_cfg("t2_cfg_reg5_zero");
    check("t2_commit_ok", 32'(ok_cnt - o0), 32'd1);
    check("t2_commit_upd", 32'(upd_cnt - u0), 32'd1);

    // 3: other board's address ignored, broadcast accepted
    o0 = ok_cnt;
    send_frame(8'h04, 8'h08, 24'h000001, 8'h0D);
    check("t3_foreign_ok", 32'(ok_cnt - o0), 32'd0);
    check("t3_foreign_err", 32'(errc), 32'h1);
    o0 = ok_cnt;
    send_frame(8'h1F, 8'h05, 24'h123456, 8'h6A);
    check("t3_bcast_ok", 32'(ok_cnt - o0), 32'd1);
    send_frame(8'h03, 8'hFF, 24'h000000, 8'hFC);
    exp_cfg[5*FW +: FW] = 24'h123456;
    check_cfg("t3_cfg");

    // 4: inter-byte timeout, then a normal frame
    send_byte(8'hAA, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h05, 1'b1);
    repeat (25 * DIV) @(posedge clk);
    check("t4_timeout_err", 32'(errc), 32'h2);
    o0 = ok_cnt;
    send_frame(8'h03, 8'h06, 24'h000099, 8'h9C);
    check("t4_after_ok", 32'(ok_cnt - o0), 32'd1);
    send_frame(8'h03, 8'hFF, 24'h000000, 8'hFC);
    exp_cfg[6*FW +: FW] = 24'h000099;
    check_cfg("t4_cfg");

    // 5: framing error mid-frame, then saturation
    o0 = ok_cnt;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h05, 1'b0);
    send_byte(8'h12, 1'b1);
    send_byte(8'h34, 1'b1);
    send_byte(8'h56, 1'b1);
    send_byte(8'h76, 1'b1);
    check("t5_frame_err", 32'(errc), 32'h3);
    check("t5_discard", 32'(ok_cnt - o0), 32'd0);
    for (int i = 0; i < 300; i++) send_byte(8'h00, 1'b0);
    check("t5_saturate", 32'(errc), 32'hFF);

    // 6: async reset mid-DATA after shadow write
    send_frame(8'h03, 8'h07, 24'hABCDEF, 8'h8D);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h03, 1'b1);
    send_byte(8'h09, 1'b1);
    send_byte(8'h00, 1'b1);
    rxb = 1'b0;
    repeat (3 * DIV) @(posedge clk);
    #13 rst = 1'b1;
    #1;
    exp_cfg = '0;
    check_cfg("t6_async_cfg");
    check("t6_async_err", 32'(errc), 32'h0);
    rxb = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    repeat (2 * DIV) @(posedge clk);
    o0 = ok_cnt;
    send_frame(8'h03, 8'h09, 24'h000042, 8'h48);
    check("t6_post_ok", 32'(ok_cnt - o0), 32'd1);
    u0 = upd_cnt;
    send_frame(8'h03, 8'hFF, 24'h000000, 8'hFC);
    exp_cfg[9*FW +: FW] = 24'h000042;
    check_cfg("t6_post_cfg");
    check("t6_post_upd", 32'(upd_cnt - u0), 32'd1);
    check("t6_post_err", 32'(errc), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_awg_cfg_rx.md
Name: uart_awg_cfg_rx

Overview:
Parametrised successor to the fixed 4-channel/3-segment UART config receiver used by the AWG board. It receives serial frames, checks the board address and an XOR checksum, and writes a shadow bank of NUM_CH x NUM_SEG x {DELAY, LEN, ADDR} registers of FIELD_W bits. A commit frame copies the shadow bank atomically to a flattened active output bus. It sits between the backplane rxb line and the AWG playback sequencers.

Parameters:
CLK_FREQ_HZ, 10000000, system clock frequency
BAUD, 115200, UART bit rate; DIV = round(CLK_FREQ_HZ/BAUD) = 87 by default
NUM_CH, 4, number of AWG channels
NUM_SEG, 3, segments per channel
FIELD_W, 24, register width; NB = ceil(FIELD_W/8) data bytes per frame
TIMEOUT_CYC, 20*DIV, idle cycles between bytes before the parser aborts the frame

Ports:
I_clk_10M  in  1  system clock
I_rst  in  1  asynchronous reset, active-high
I_rxb  in  1  UART line, asynchronous, idle high
I_GA  in  5  board geographic address
O_cfg  out  NREG*FIELD_W  active bank, NREG = 3*NUM_CH*NUM_SEG; register k at [k*FIELD_W +: FIELD_W]
O_cfg_update  out  1  one-cycle pulse when the active bank changes
O_frame_ok  out  1  one-cycle pulse per accepted frame
O_err_cnt  out  8  saturating count of framing, checksum and timeout errors

Behaviour:
- Reset: shadow bank, O_cfg, O_err_cnt and all pulses are 0. The parser goes to IDLE and the rx sampler to idle. Reset mid-frame discards the partial frame.
- Build-time check: NREG must be <= 255, otherwise elaboration fails.
- Register index: k = field*NUM_CH*NUM_SEG + seg*NUM_CH + ch, with field 0=DELAY, 1=LEN, 2=ADDR.
- rx sampler:
  - I_rxb passes through a 2-FF synchroniser.
  - A falling edge in idle starts a bit counter. The start bit is sampled at DIV/2 and must read low, otherwise the sampler returns to idle.
  - The 8 data bits (LSB first) are sampled every DIV cycles.
  - The stop bit must read high. If it does, a 1-cycle byte_vld is issued. If it reads low, a framing error is raised and no byte is issued.
- Frame format: 0xAA, GA, IDX, D[NB-1]..D[0] (MSB first), CSUM. CSUM = XOR of GA, IDX and all data bytes.
- Parser states: IDLE, GA, IDX, DATA, CSUM.
  - IDLE: byte 0xAA goes to GA; any other byte is ignored.
  - GA: always goes to IDX; records match = (byte == {3'b0, I_GA}) or (byte == 0x1F, broadcast).
  - IDX: stores the index and goes to DATA.
  - DATA: assembles NB bytes into a shift register, then goes to CSUM.
  - CSUM: on arrival, returns to IDLE.
- On CSUM arrival:
  - Checksum mismatch: err++ (only when match is set); no write.
  - Checksum good, match set, IDX < NREG: shadow[IDX] <= data[FIELD_W-1:0]; O_frame_ok pulses.
  - Checksum good, match set, IDX == 0xFF (commit): O_cfg <= shadow on the next cycle, then O_cfg_update and O_frame_ok pulse in that same cycle.
  - IDX in NREG..0xFE: silently dropped, no error, O_frame_ok does not pulse.
  - match clear: the frame is consumed silently.
- Data bits above FIELD_W are ignored.
- Timeout: in any state other than IDLE, TIMEOUT_CYC cycles without byte_vld force IDLE and err++.
- Framing error mid-frame: err++ and force IDLE.
- Simultaneous error sources in one cycle count as 1.
- O_err_cnt saturates at 0xFF.
- Latency: write/commit effects appear 1 cycle after the byte_vld of CSUM.

Decomposition:
- Package uart_awg_pkg:
  - frame constants HDR=0xAA, BCAST_GA=0x1F, IDX_COMMIT=0xFF;
  - field enum {DELAY, LEN, ADDR};
  - function reg_idx(field, seg, ch).
- Sub-module uart_rx_byte(DIV) holds the synchroniser, sampler and framing check. It outputs byte[7:0], byte_vld and frame_err.

Test Plan:
1. I_GA=3, send AA 03 05 12 34 56 76, then AA 03 FF 00 00 00 FC -> after the first frame O_cfg is unchanged and O_frame_ok pulses once. After the commit, reg 5 (CH2 DELAY2) = 0x123456, O_cfg_update pulses once and all other registers stay 0.
2. Same write frame with CSUM=0x77 -> no write, O_err_cnt=1, O_frame_ok low. A following good commit leaves reg 5 = 0.
3. GA byte 0x04 with I_GA=3 and a valid checksum -> frame ignored, err unchanged. Broadcast GA 0x1F with its correct checksum -> write accepted.
4. Send AA 03 05, then hold the line idle > TIMEOUT_CYC -> err=1, parser in IDLE. The next full frame is accepted normally.
5. Byte with stop bit forced low inside a frame -> err increments and the frame is discarded. 300 bad frames -> O_err_cnt holds at 0xFF.
6. Assert I_rst mid-DATA after an earlier commit -> O_cfg, shadow and err are 0 immediately (asynchronously). The first post-reset frame is decoded correctly.
